// File: rtl/mbist_march_engine.sv
// March-test BIST engine for a synchronous single-port SRAM (MATS+, March C-, March X).
// One memory op per cycle, pipelined read compare, first-fail capture and saturating fail count.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start; capture regs and fail hold last run
// RUN   | issuing one March op per cycle
// DRAIN | last read compared; no memory access
// DONE  | one-cycle done pulse, then back to IDLE
module mbist_march_engine #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [1:0]        i_alg_sel,
  input  logic [DATA_W-1:0] i_bg,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_we,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_fail,
  output logic              o_sel_err,
  output logic [CNT_W-1:0]  o_fail_count,
  output logic [ADDR_W-1:0] o_fail_addr,
  output logic [DATA_W-1:0] o_fail_exp,
  output logic [DATA_W-1:0] o_fail_got,
  output logic [2:0]        o_fail_elem
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [1:0]        ALG_ILLEGAL = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  // op*_wr: 1 = write, 0 = read; op*_val: 0 = background, 1 = inverted background
  typedef struct packed {
    logic two;
    logic last;
    logic op0_wr;
    logic op0_val;
    logic op1_wr;
    logic op1_val;
  } elem_t;

  function automatic elem_t elem_desc(input logic [1:0] alg, input logic [2:0] elem);
    elem_t d;
    d = '0;
    case (elem)
      3'd0: d.op0_wr = 1'b1;
      3'd1: begin
        d.two     = 1'b1;
        d.op1_wr  = 1'b1;
        d.op1_val = 1'b1;
      end
      3'd2: begin
        d.two     = 1'b1;
        d.op0_val = 1'b1;
        d.op1_wr  = 1'b1;
        d.last    = (alg == 2'd0);
      end
      3'd3: begin
        if (alg == 2'd1) begin
          d.two     = 1'b1;
          d.op1_wr  = 1'b1;
          d.op1_val = 1'b1;
        end else begin
          d.last = 1'b1;
        end
      end
      3'd4: begin
        d.two     = 1'b1;
        d.op0_val = 1'b1;
        d.op1_wr  = 1'b1;
      end
      default: d.last = 1'b1;
    endcase
    return d;
  endfunction

  function automatic logic elem_down(input logic [1:0] alg, input logic [2:0] elem);
    logic down;
    down = 1'b0;
    case (elem)
      3'd2:    down = (alg != 2'd1);
      3'd3:    down = (alg == 2'd1);
      3'd4:    down = 1'b1;
      default: down = 1'b0;
    endcase
    return down;
  endfunction

  state_t              r_state, w_next;
  logic [1:0]          r_alg;
  logic [DATA_W-1:0]   r_bg;
  logic [2:0]          r_elem;
  logic                r_opi;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata_hold;

  logic                r_cmp_v;
  logic [DATA_W-1:0]   r_cmp_exp;
  logic [ADDR_W-1:0]   r_cmp_addr;
  logic [2:0]          r_cmp_elem;

  logic                r_fail;
  logic                r_sel_err;
  logic [CNT_W-1:0]    r_fail_count;
  logic [ADDR_W-1:0]   r_fail_addr;
  logic [DATA_W-1:0]   r_fail_exp;
  logic [DATA_W-1:0]   r_fail_got;
  logic [2:0]          r_fail_elem;

  elem_t               w_cur;
  logic                w_down;
  logic                w_nxt_down;
  logic                w_op_wr;
  logic                w_op_val;
  logic [DATA_W-1:0]   w_op_data;
  logic                w_at_end;
  logic                w_elem_op_last;
  logic                w_run_last;
  logic                w_accept;
  logic                w_miscompare;

  always_comb begin
    w_cur          = elem_desc(r_alg, r_elem);
    w_down         = elem_down(r_alg, r_elem);
    w_nxt_down     = elem_down(r_alg, r_elem + 3'd1);
    w_op_wr        = r_opi ? w_cur.op1_wr : w_cur.op0_wr;
    w_op_val       = r_opi ? w_cur.op1_val : w_cur.op0_val;
    w_op_data      = w_op_val ? ~r_bg : r_bg;
    w_at_end       = w_down ? (r_addr == '0) : (r_addr == ADDR_LAST);
    w_elem_op_last = !w_cur.two || r_opi;
    w_run_last     = w_elem_op_last && w_at_end && w_cur.last;
    w_accept       = (r_state == S_IDLE) && i_start;
    w_miscompare   = r_cmp_v && (i_mem_rdata != r_cmp_exp);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_wdata = r_wdata_hold;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_next = (i_alg_sel == ALG_ILLEGAL) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        o_busy      = 1'b1;
        o_mem_we    = w_op_wr;
        o_mem_wdata = w_op_data;
        if (w_run_last) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        o_busy = 1'b1;
        w_next = S_DONE;
      end
      S_DONE: begin
        o_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Sequencer: r_elem/r_opi/r_addr always name the op being issued this cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_alg        <= '0;
      r_bg         <= '0;
      r_elem       <= '0;
      r_opi        <= 1'b0;
      r_addr       <= '0;
      r_wdata_hold <= '0;
    end else if (w_accept && (i_alg_sel != ALG_ILLEGAL)) begin
      r_alg  <= i_alg_sel;
      r_bg   <= i_bg;
      r_elem <= '0;
      r_opi  <= 1'b0;
      r_addr <= '0;
    end else if (r_state == S_RUN) begin
      r_wdata_hold <= w_op_data;
      if (!w_run_last) begin
        if (!w_elem_op_last) begin
          r_opi <= 1'b1;
        end else begin
          r_opi <= 1'b0;
          if (w_at_end) begin
            r_elem <= r_elem + 3'd1;
            r_addr <= w_nxt_down ? ADDR_LAST : '0;
          end else begin
            r_addr <= w_down ? (r_addr - 1'b1) : (r_addr + 1'b1);
          end
        end
      end
    end
  end

  // Read compare runs one cycle behind the read, so the final read lands in DRAIN.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cmp_v      <= 1'b0;
      r_cmp_exp    <= '0;
      r_cmp_addr   <= '0;
      r_cmp_elem   <= '0;
      r_fail       <= 1'b0;
      r_sel_err    <= 1'b0;
      r_fail_count <= '0;
      r_fail_addr  <= '0;
      r_fail_exp   <= '0;
      r_fail_got   <= '0;
      r_fail_elem  <= '0;
    end else begin
      r_cmp_v    <= (r_state == S_RUN) && !w_op_wr;
      r_cmp_exp  <= w_op_data;
      r_cmp_addr <= r_addr;
      r_cmp_elem <= r_elem;
      if (w_accept) begin
        r_sel_err    <= (i_alg_sel == ALG_ILLEGAL);
        r_fail       <= 1'b0;
        r_fail_count <= '0;
        r_fail_addr  <= '0;
        r_fail_exp   <= '0;
        r_fail_got   <= '0;
        r_fail_elem  <= '0;
      end else if (w_miscompare) begin
        r_fail <= 1'b1;
        if (r_fail_count != '1) r_fail_count <= r_fail_count + 1'b1;
        if (!r_fail) begin
          r_fail_addr <= r_cmp_addr;
          r_fail_exp  <= r_cmp_exp;
          r_fail_got  <= i_mem_rdata;
          r_fail_elem <= r_cmp_elem;
        end
      end
    end
  end

  assign o_mem_addr   = r_addr;
  assign o_fail       = r_fail;
  assign o_sel_err    = r_sel_err;
  assign o_fail_count = r_fail_count;
  assign o_fail_addr  = r_fail_addr;
  assign o_fail_exp   = r_fail_exp;
  assign o_fail_got   = r_fail_got;
  assign o_fail_elem  = r_fail_elem;

endmodule

// File: tb/tb_mbist_march_engine.sv
// Bench for mbist_march_engine: behavioural SRAM with stuck-at fault injection,
// op-stream scoreboard built from the March element lists, table of run vectors.
module tb_mbist_march_engine;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;
  localparam int DATA_W = 4;
  localparam int CNT_W  = 8;

  localparam int R0 = 0, R1 = 1, W0 = 2, W1 = 3;

  logic              i_clk, i_rst, i_start;
  logic [1:0]        i_alg_sel;
  logic [DATA_W-1:0] i_bg;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [DATA_W-1:0] o_mem_wdata;
  logic              o_mem_we;
  logic [DATA_W-1:0] tb_rdata;
  logic              o_busy, o_done, o_fail, o_sel_err;
  logic [CNT_W-1:0]  o_fail_count;
  logic [ADDR_W-1:0] o_fail_addr;
  logic [DATA_W-1:0] o_fail_exp, o_fail_got;
  logic [2:0]        o_fail_elem;

  mbist_march_engine #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_alg_sel(i_alg_sel), .i_bg(i_bg),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_we(o_mem_we),
    .i_mem_rdata(tb_rdata), .o_busy(o_busy), .o_done(o_done), .o_fail(o_fail),
    .o_sel_err(o_sel_err), .o_fail_count(o_fail_count), .o_fail_addr(o_fail_addr),
    .o_fail_exp(o_fail_exp), .o_fail_got(o_fail_got), .o_fail_elem(o_fail_elem)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // fmode: 0 = fault-free, 1 = bit0 stuck-at-1 at faddr, 2 = bit0 stuck-at-1 everywhere
  logic [DATA_W-1:0] mem [DEPTH];
  int                fmode;
  logic [ADDR_W-1:0] faddr;

  always @(posedge i_clk) begin
    if (o_mem_we) mem[o_mem_addr] <= o_mem_wdata;
    tb_rdata <= mem[o_mem_addr] |
                (((fmode == 2) || (fmode == 1 && o_mem_addr == faddr)) ? DATA_W'(1) : DATA_W'(0));
  end

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } op_t;
  op_t q[$];

  int n_chk, n_pass;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic add_elem(input logic down, input int n, input int op0, input int op1,
                          input logic [DATA_W-1:0] bg);
    for (int i = 0; i < DEPTH; i++) begin
      int a;
      a = down ? (DEPTH - 1 - i) : i;
      for (int j = 0; j < n; j++) begin
        int  op;
        op_t e;
        op     = (j == 0) ? op0 : op1;
        e.we   = (op >= W0);
        e.addr = ADDR_W'(a);
        e.data = (op == R1 || op == W1) ? ~bg : bg;
        q.push_back(e);
      end
    end
  endtask

  task automatic gen_ops(input int alg, input logic [DATA_W-1:0] bg);
    case (alg)
      0: begin
        add_elem(0, 1, W0, 0, bg);  add_elem(0, 2, R0, W1, bg);
        add_elem(1, 2, R1, W0, bg);
      end
      1: begin
        add_elem(0, 1, W0, 0, bg);  add_elem(0, 2, R0, W1, bg);
        add_elem(0, 2, R1, W0, bg); add_elem(1, 2, R0, W1, bg);
        add_elem(1, 2, R1, W0, bg); add_elem(0, 1, R0, 0, bg);
      end
      2: begin
        add_elem(0, 1, W0, 0, bg);  add_elem(0, 2, R0, W1, bg);
        add_elem(1, 2, R1, W0, bg); add_elem(0, 1, R0, 0, bg);
      end
      default: ;
    endcase
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".mem_we"},     o_mem_we,     0);
    check({tag, ".mem_addr"},   o_mem_addr,   0);
    check({tag, ".mem_wdata"},  o_mem_wdata,  0);
    check({tag, ".busy"},       o_busy,       0);
    check({tag, ".done"},       o_done,       0);
    check({tag, ".fail"},       o_fail,       0);
    check({tag, ".sel_err"},    o_sel_err,    0);
    check({tag, ".fail_count"}, o_fail_count, 0);
    check({tag, ".fail_addr"},  o_fail_addr,  0);
    check({tag, ".fail_exp"},   o_fail_exp,   0);
    check({tag, ".fail_got"},   o_fail_got,   0);
    check({tag, ".fail_elem"},  o_fail_elem,  0);
  endtask

  // Runs one start; restart_cyc pulses a stray start, abort_cyc resets mid-run.
  task automatic do_run(input int alg, input logic [DATA_W-1:0] bg, input int exp_done,
                        input int restart_cyc, input int abort_cyc, input string tag);
    int  done_at, done_n, busy_n, stray_we;
    op_t e;
    q.delete();
    gen_ops(alg, bg);
    done_at = 0; done_n = 0; busy_n = 0; stray_we = 0;
    @(negedge i_clk);
    i_start = 1'b1; i_alg_sel = 2'(alg); i_bg = bg;
    @(negedge i_clk);
    i_start = 1'b0;
    for (int cyc = 1; cyc <= exp_done + 20; cyc++) begin
      if (cyc == abort_cyc) begin
        check({tag, ".pre_rst_fail"}, o_fail, 1);
        check({tag, ".pre_rst_busy"}, o_busy, 1);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        check_zero({tag, ".rst"});
        q.delete();
        return;
      end
      if (cyc == restart_cyc) begin
        i_start = 1'b1; i_alg_sel = 2'd1; i_bg = ~bg;
      end else if (cyc == restart_cyc + 1) begin
        i_start = 1'b0;
      end
      if (o_busy) busy_n++;
      if (o_done) begin
        done_n++;
        if (done_at == 0) done_at = cyc;
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        check($sformatf("%s.op%0d.addr", tag, cyc), o_mem_addr, e.addr);
        check($sformatf("%s.op%0d.we", tag, cyc), o_mem_we, e.we);
        if (e.we) check($sformatf("%s.op%0d.wdata", tag, cyc), o_mem_wdata, e.data);
      end else if (o_mem_we) begin
        stray_we++;
      end
      if (done_at != 0 && cyc >= done_at + 2) break;
      @(negedge i_clk);
    end
    check({tag, ".done_cycle"}, done_at, exp_done);
    check({tag, ".done_pulses"}, done_n, 1);
    check({tag, ".busy_cycles"}, busy_n, exp_done - 1);
    check({tag, ".stray_we"}, stray_we, 0);
    check({tag, ".ops_left"}, q.size(), 0);
  endtask

  typedef struct {
    int                alg;
    logic [DATA_W-1:0] bg;
    int                fmode;
    logic [ADDR_W-1:0] faddr;
    int                done_cyc;
    logic              fail;
    int                cnt;
    logic [ADDR_W-1:0] f_addr;
    logic [DATA_W-1:0] f_exp;
    logic [DATA_W-1:0] f_got;
    logic [2:0]        f_elem;
    logic              sel_err;
  } vec_t;

  vec_t vt[8];

  initial begin
    vt[0] = '{0, 4'h0, 0, 8'h00, 1282, 1'b0,   0, 8'h00, 4'h0, 4'h0, 3'd0, 1'b0};
    vt[1] = '{1, 4'hA, 0, 8'h00, 2562, 1'b0,   0, 8'h00, 4'h0, 4'h0, 3'd0, 1'b0};
    vt[2] = '{1, 4'h0, 1, 8'h37, 2562, 1'b1,   3, 8'h37, 4'h0, 4'h1, 3'd1, 1'b0};
    vt[3] = '{3, 4'h0, 0, 8'h00,    1, 1'b0,   0, 8'h00, 4'h0, 4'h0, 3'd0, 1'b1};
    vt[4] = '{2, 4'h0, 0, 8'h00, 1538, 1'b0,   0, 8'h00, 4'h0, 4'h0, 3'd0, 1'b0};
    vt[5] = '{0, 4'h5, 1, 8'h10, 1282, 1'b1,   1, 8'h10, 4'hA, 4'hB, 3'd2, 1'b0};
    vt[6] = '{2, 4'h6, 1, 8'hFF, 1538, 1'b1,   2, 8'hFF, 4'h6, 4'h7, 3'd1, 1'b0};
    vt[7] = '{1, 4'h0, 2, 8'h00, 2562, 1'b1, 255, 8'h00, 4'h0, 4'h1, 3'd1, 1'b0};

    n_chk = 0; n_pass = 0;
    fmode = 0; faddr = '0;
    i_rst = 1'b1; i_start = 1'b0; i_alg_sel = 2'd0; i_bg = '0;
    repeat (2) @(negedge i_clk);
    check_zero("reset");
    i_rst = 1'b0;

    for (int r = 0; r < 8; r++) begin
      string tag;
      tag   = $sformatf("row%0d", r);
      fmode = vt[r].fmode;
      faddr = vt[r].faddr;
      do_run(vt[r].alg, vt[r].bg, vt[r].done_cyc, 0, 0, tag);
      check({tag, ".fail"}, o_fail, vt[r].fail);
      check({tag, ".fail_count"}, o_fail_count, vt[r].cnt);
      check({tag, ".sel_err"}, o_sel_err, vt[r].sel_err);
      if (vt[r].fail) begin
        check({tag, ".fail_addr"}, o_fail_addr, vt[r].f_addr);
        check({tag, ".fail_exp"}, o_fail_exp, vt[r].f_exp);
        check({tag, ".fail_got"}, o_fail_got, vt[r].f_got);
        check({tag, ".fail_elem"}, o_fail_elem, vt[r].f_elem);
      end
    end

    fmode = 0;
    do_run(0, 4'h3, 1282, 100, 0, "restart");
    check("restart.fail", o_fail, 0);

    fmode = 1; faddr = 8'h37;
    do_run(2, 4'h0, 1538, 0, 600, "abort");
    fmode = 0;
    do_run(2, 4'h9, 1538, 0, 0, "after_rst");
    check("after_rst.fail", o_fail, 0);
    check("after_rst.fail_count", o_fail_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mbist_march_engine.md
Name: mbist_march_engine

Overview:
- Parametrised memory BIST engine; next generation of the BIST_engine_top/SRAM pairing.
- Runs one of three selectable March algorithms over a synchronous single-port SRAM of configurable width and depth, one memory operation per cycle.
- Adds a start/busy/done handshake, a programmable data background, and first-fail capture with a saturating fail counter.
- Sits between the test controller (or bench) and the SRAM's dat_in/addr_in/w_en/read_d ports.

Parameters:
- ADDR_W, 8, address width.
- DEPTH, 256, number of words tested, addresses 0..DEPTH-1; must satisfy 1 <= DEPTH <= 2^ADDR_W.
- DATA_W, 4, memory word width.
- CNT_W, 8, fail counter width.

Ports:
- clk, in, 1, rising-edge clock.
- rst, in, 1, synchronous active-high reset.
- start, in, 1, run request; sampled only while idle.
- alg_sel, in, 2, algorithm select: 0 = MATS+, 1 = March C-, 2 = March X, 3 = illegal.
- bg, in, DATA_W, data background; latched at start.
- mem_addr, out, ADDR_W, SRAM address.
- mem_wdata, out, DATA_W, SRAM write data.
- mem_we, out, 1, SRAM write enable.
- mem_rdata, in, DATA_W, SRAM read data; valid one cycle after a read is issued.
- busy, out, 1, run in progress.
- done, out, 1, one-cycle completion pulse.
- fail, out, 1, sticky: at least one miscompare this run.
- sel_err, out, 1, last start used alg_sel = 3.
- fail_count, out, CNT_W, miscompare count; saturates at all-ones.
- fail_addr, out, ADDR_W, address of the first miscompare.
- fail_exp, out, DATA_W, expected data at the first miscompare.
- fail_got, out, DATA_W, read data at the first miscompare.
- fail_elem, out, 3, March element index (0-based) of the first miscompare.

Behaviour:
- Reset (and reset mid-run): all outputs 0, mem_we = 0, FSM to IDLE, pending compare discarded.
- Data values: "0" = latched bg, "1" = ~bg.
- Address order: up = 0..DEPTH-1; down = DEPTH-1..0; either = up.
- Algorithms:
  - MATS+: up(w0); up(r0,w1); down(r1,w0).
  - March C-: up(w0); up(r0,w1); up(r1,w0); down(r0,w1); down(r1,w0); up(r0).
  - March X: up(w0); up(r0,w1); down(r1,w0); up(r0).
- Total operation count OPS = 5/10/6 × DEPTH respectively.
- FSM states: IDLE -> RUN -> DRAIN -> DONE -> IDLE.
  - IDLE: start = 1 with a legal alg_sel -> clear fail, fail_count and all capture regs; latch bg and alg_sel; go to RUN.
  - RUN: ops are issued in element order; within an element all ops complete at one address before the address advances.
  - After the last op -> DRAIN for one cycle (final compare) -> DONE.
  - DONE: done = 1 for exactly one cycle -> IDLE.
- Cycle timing: start sampled at edge 0; op k issues in cycle k (k = 1..OPS); busy = 1 in cycles 1..OPS+1; done = 1 in cycle OPS+2.
- Outputs are idle-valued whenever not issuing an op: mem_we = 0, mem_addr and mem_wdata hold.
- Read pipeline:
  - Each read registers its expected value, address and element index.
  - Compare happens the next cycle against mem_rdata, with no stall.
  - Back-to-back reads are fully pipelined.
- Miscompare handling:
  - fail_count increments, saturating at all-ones.
  - On the first miscompare of a run, fail_addr, fail_exp, fail_got and fail_elem are captured.
  - fail goes to 1 and stays until the next accepted start.
- Capture registers and fail hold their values after done until the next accepted start.
- start while busy: ignored; the run is unaffected.
- alg_sel = 3 at start: no memory access; sel_err = 1 and done = 1 in cycle 1; busy stays 0; fail and fail_count are 0.
- A legal start clears sel_err.
- DEPTH = 1: up and down orders are identical; timing follows the same formula.

Test Plan:
- Fault-free SRAM, DEPTH=256, DATA_W=4, alg_sel=0, bg=4'h0 -> done pulses in cycle 1282, busy for cycles 1..1281, fail=0, fail_count=0.
- Fault-free SRAM, alg_sel=1, bg=4'hA -> done in cycle 2562, fail=0; a mem_wdata probe shows alternating 4'hA and 4'h5.
- SRAM with addr 0x37 bit0 stuck-at-1, alg_sel=1, bg=4'h0 -> fail=1, fail_count=3, fail_addr=0x37, fail_exp=4'h0, fail_got=4'h1, fail_elem=1.
- alg_sel=3 with start -> done and sel_err in cycle 1, mem_we never asserted; a following alg_sel=2 run clears sel_err and completes in cycle 1538.
- rst asserted mid-run during March X element 2 -> next cycle all outputs 0 and mem_we=0; a fresh start runs to completion with correct timing.
- start pulsed again at cycle 100 of a MATS+ run -> ignored; done still lands in cycle 1282 with a single pulse.
